// File: rtl/bau_pkg.sv
// Shared types and the per-bit beat function for bitwise_accum_unit.
package bau_pkg;

    typedef enum logic [1:0] {
        OP_XOR  = 2'd0,
        OP_AND  = 2'd1,
        OP_OR   = 2'd2,
        OP_COND = 2'd3
    } bau_op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } bau_state_e;

    // One bit of the beat result; sign is operand A's MSB, which steers COND.
    // Applied across every bit position, this gives r for any WIDTH.
    function automatic logic bau_op(input bau_op_e op, input logic a, input logic b,
                                    input logic sign);
        case (op)
            OP_XOR:  return a ^ b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_COND: return sign ? (a & b) : (a ^ b);
            default: return a ^ b;
        endcase
    endfunction

endpackage

// File: rtl/bau_out_reg.sv
// Output holding register: payload is held stable until the downstream takes it.
module bau_out_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q
);

    // load is only raised while the register is empty or draining this cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bitwise_accum_unit.sv
// Per-beat bitwise op on a valid/ready stream, either passed through or XOR-folded per packet.
//   state    | meaning
//   ST_IDLE  | no open packet; next accepted beat starts one
//   ST_ACCUM | accumulate packet open, acc/cnt hold the partial fold
module bitwise_accum_unit
    import bau_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int BURST_MAX = 8,
    localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_acc,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err
);

    bau_state_e       state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             emit;
    logic [WIDTH-1:0] emit_data;
    logic [CNT_W-1:0] emit_count;
    logic             emit_err;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign acc_sum  = acc ^ r;
    assign cnt_inc  = cnt + 1'b1;

    always_comb begin
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = bau_op(bau_op_e'(in_op), in_a[i], in_b[i], in_a[WIDTH-1]);
        end
    end

    always_comb begin
        emit       = 1'b0;
        emit_data  = r;
        emit_count = CNT_W'(1);
        emit_err   = 1'b0;
        if (accept) begin
            if (state == ST_IDLE) begin
                emit = !in_acc || in_last;
            end else begin
                emit_data  = acc_sum;
                emit_count = cnt_inc;
                if (in_last) begin
                    emit = 1'b1;
                end else if (cnt_inc == CNT_W'(BURST_MAX)) begin
                    emit     = 1'b1;
                    emit_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else if (accept) begin
            if (emit) begin
                state <= ST_IDLE;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == ST_IDLE) begin
                state <= ST_ACCUM;
                acc   <= r;
                cnt   <= CNT_W'(1);
            end else begin
                acc   <= acc_sum;
                cnt   <= cnt_inc;
            end
        end
    end

    bau_out_reg #(
        .W(WIDTH + CNT_W + 1)
    ) u_out_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (emit),
        .d     ({emit_data, emit_count, emit_err}),
        .ready (out_ready),
        .valid (out_valid),
        .q     ({out_data, out_count, out_err})
    );

endmodule

// File: tb/tb_bitwise_accum_unit.sv
// Directed and random checks of bitwise_accum_unit against a packet-level reference model.
module tb_bitwise_accum_unit;

    localparam int WIDTH     = 8;
    localparam int BURST_MAX = 4;
    localparam int CNT_W     = $clog2(BURST_MAX + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_acc;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_err;

    int n_assert = 0;
    int n_fail   = 0;

    // reference packet state
    bit       m_open = 0;
    int       m_acc  = 0;
    int       m_cnt  = 0;
    bit       e_emit;
    int       e_data;
    int       e_count;
    bit       e_err;

    always #5 clk = ~clk;

    bitwise_accum_unit #(
        .WIDTH(WIDTH),
        .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count), .out_err(out_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_r(input int op, input int a, input int b);
        case (op)
            0: return a ^ b;
            1: return a & b;
            2: return a | b;
            default: return (a >= 128) ? (a & b) : (a ^ b);
        endcase
    endfunction

    // packet rules applied to one accepted beat; sets e_* for the expected emission
    task automatic model_beat(input int a, input int b, input int op, input bit acc, input bit last);
        int r;
        r      = ref_r(op, a, b);
        e_emit = 0;
        e_err  = 0;
        if (!m_open) begin
            if (!acc || last) begin
                e_emit = 1; e_data = r; e_count = 1;
            end else begin
                m_open = 1; m_acc = r; m_cnt = 1;
            end
        end else begin
            m_acc = m_acc ^ r;
            m_cnt = m_cnt + 1;
            if (last || m_cnt == BURST_MAX) begin
                e_emit = 1; e_data = m_acc; e_count = m_cnt; e_err = !last;
                m_open = 0; m_acc = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, ".valid"}, int'(out_valid), int'(e_emit));
        if (e_emit) begin
            check({tag, ".data"},  int'(out_data),  e_data);
            check({tag, ".count"}, int'(out_count), e_count);
            check({tag, ".err"},   int'(out_err),   int'(e_err));
        end
    endtask

    // one beat with the downstream ready; result must show 1 cycle after accept
    task automatic beat(input string tag, input int a, input int b, input int op,
                        input bit acc, input bit last);
        in_a = WIDTH'(a); in_b = WIDTH'(b); in_op = 2'(op);
        in_acc = acc; in_last = last; in_valid = 1'b1;
        #1;
        check({tag, ".in_ready"}, int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_beat(a, b, op, acc, last);
        check_out(tag);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_a = 8'h0F; in_b = 8'h35; in_op = 2'd0; in_acc = 1'b0; in_last = 1'b0;

        // reset held 2 cycles with a valid beat present
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("rst.out_valid", int'(out_valid), 0);
            check("rst.out_data",  int'(out_data),  0);
            check("rst.out_count", int'(out_count), 0);
            check("rst.out_err",   int'(out_err),   0);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.idle_valid", int'(out_valid), 0);

        // pass mode, COND
        beat("pass_cond0", 8'h0F, 8'h35, 3, 0, 0);
        check("pass_cond0.lit", int'(out_data), 8'h3A);
        beat("pass_cond1", 8'h8F, 8'hB5, 3, 0, 1);
        check("pass_cond1.lit", int'(out_data), 8'h85);
        idle_cycle();
        check("pass.drained", int'(out_valid), 0);

        // accumulate, AND, 3 beats
        beat("acc_and0", 8'hFF, 8'h11, 1, 1, 0);
        beat("acc_and1", 8'hF0, 8'h3C, 1, 0, 0);
        beat("acc_and2", 8'h0F, 8'h0F, 1, 0, 1);
        check("acc_and.lit", int'(out_data), 8'h2E);
        check("acc_and.cnt", int'(out_count), 3);
        idle_cycle();

        // backpressure: result held while downstream stalls
        out_ready = 1'b0;
        beat("bp_pass", 8'h0F, 8'h35, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            idle_cycle();
            check("bp.in_ready", int'(in_ready), 0);
            check("bp.valid", int'(out_valid), 1);
            check("bp.hold", int'(out_data), 8'h3A);
        end
        in_a = 8'h8F; in_b = 8'hB5; in_op = 2'd3; in_acc = 1'b0; in_last = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("bp.release_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_beat(8'h8F, 8'hB5, 3, 0, 0);
        check_out("bp.same_cycle");
        check("bp.new_lit", int'(out_data), 8'h85);
        idle_cycle();

        // overflow at BURST_MAX without in_last
        for (int i = 0; i < 4; i++) beat("ovf", 8'h01, 8'h00, 0, 1, 0);
        check("ovf.data", int'(out_data), 0);
        check("ovf.cnt", int'(out_count), 4);
        check("ovf.err", int'(out_err), 1);
        beat("ovf.next", 8'h01, 8'h00, 0, 1, 1);
        check("ovf.next_err", int'(out_err), 0);
        check("ovf.next_cnt", int'(out_count), 1);

        // reset mid-packet discards the partial fold
        beat("rmid0", 8'h55, 8'hAA, 2, 1, 0);
        beat("rmid1", 8'h33, 8'h0F, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_open = 0; m_acc = 0; m_cnt = 0;
        check("rmid.valid", int'(out_valid), 0);
        beat("rmid.pass", 8'h0F, 8'h35, 0, 0, 0);
        check("rmid.lit", int'(out_data), 8'h3A);
        idle_cycle();

        // random beats, random gaps
        for (int i = 0; i < 300; i++) begin
            beat("rnd", int'($urandom_range(255)), int'($urandom_range(255)),
                 int'($urandom_range(3)), bit'($urandom_range(1)),
                 ($urandom_range(3) == 0));
            if ($urandom_range(3) == 0) begin
                idle_cycle();
                check("rnd.gap_valid", int'(out_valid), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
